// File: rtl/fused_load_pkg.sv
// Shared types for the fused-layer load sequencer: FSM states, phase tags,
// default bank counts and the phase-ordering helpers.
package fused_load_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_IFM = 3'd1,
    RD_W1  = 3'd2,
    RD_W2  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_IFM = 2'd0,
    PH_W1  = 2'd1,
    PH_W2  = 2'd2
  } phase_t;

  localparam int N_W1_DEFAULT = 16;
  localparam int N_W2_DEFAULT = 4;

  // Next read phase after 'from', skipping empty phases; DRAIN when none remain.
  function automatic state_t next_read_state(input state_t from, input logic nz_ifm,
                                             input logic nz_w1, input logic nz_w2);
    state_t res;
    res = DRAIN;
    case (from)
      IDLE: begin
        if (nz_ifm)     res = RD_IFM;
        else if (nz_w1) res = RD_W1;
        else if (nz_w2) res = RD_W2;
        else            res = DRAIN;
      end
      RD_IFM: begin
        if (nz_w1)      res = RD_W1;
        else if (nz_w2) res = RD_W2;
        else            res = DRAIN;
      end
      RD_W1: begin
        if (nz_w2) res = RD_W2;
        else       res = DRAIN;
      end
      default: res = DRAIN;
    endcase
    return res;
  endfunction

  function automatic phase_t phase_of(input state_t s);
    phase_t res;
    case (s)
      RD_W1:   res = PH_W1;
      RD_W2:   res = PH_W2;
      default: res = PH_IFM;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fused_bank_decode.sv
// Maps an issued (phase tag, word index k) onto a one-hot bank write enable
// and the in-bank address; N_BANKS must be a power of two (1 for the IFM).
module fused_bank_decode
  import fused_load_pkg::*;
#(
  parameter int     N_BANKS = 4,
  parameter int     ADDR_W  = 32,
  parameter int     LADDR_W = 16,
  parameter phase_t PHASE   = PH_W1
) (
  input  logic               valid,
  input  phase_t             tag,
  input  logic [ADDR_W-1:0]  k,
  output logic [N_BANKS-1:0] we,
  output logic [LADDR_W-1:0] addr
);

  localparam int SHIFT = $clog2(N_BANKS);

  logic              hit_s;
  logic [ADDR_W-1:0] bank_s;

  // Word k lands in bank k mod N at row k / N, truncated to the local width.
  always_comb begin
    hit_s  = valid && (tag == PHASE);
    bank_s = k & ADDR_W'(N_BANKS - 1);
    addr   = LADDR_W'(k >> SHIFT);
    for (int i = 0; i < N_BANKS; i++) begin
      we[i] = hit_s && (bank_s == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/fused_load_sequencer.sv
// Copies one fused-layer working set (IFM, layer-1 and layer-2 weights) from the
// global BRAM into the local BRAMs with a one-stage read-to-write pipeline.
module fused_load_sequencer
  import fused_load_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int LADDR_W = 16,
  parameter int N_W1    = N_W1_DEFAULT,
  parameter int N_W2    = N_W2_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr_IFM,
  input  logic [ADDR_W-1:0]  size_IFM,
  input  logic [ADDR_W-1:0]  base_addr_Weight_layer_1,
  input  logic [ADDR_W-1:0]  size_Weight_layer_1,
  input  logic [ADDR_W-1:0]  base_addr_Weight_layer_2,
  input  logic [ADDR_W-1:0]  size_Weight_layer_2,
  output logic [ADDR_W-1:0]  rd_addr_global,
  input  logic [DATA_W-1:0]  rd_data_global,
  output logic [DATA_W-1:0]  wr_data_fused,
  output logic [LADDR_W-1:0] wr_addr_IFM,
  output logic               we_IFM,
  output logic [LADDR_W-1:0] wr_addr_Weight_layer_1,
  output logic [N_W1-1:0]    we_Weight_layer_1,
  output logic [LADDR_W-1:0] wr_addr_Weight_layer_2,
  output logic [N_W2-1:0]    we_Weight_layer_2,
  output logic               busy,
  output logic               done
);

  state_t              state_r;
  logic [ADDR_W-1:0]   base_ifm_r, size_ifm_r, base_w1_r, size_w1_r, base_w2_r, size_w2_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                pipe_valid_r;
  phase_t              pipe_tag_r;
  logic [ADDR_W-1:0]   pipe_k_r;
  logic                busy_r, done_r;

  logic                we_ifm_r;
  logic [N_W1-1:0]     we_w1_r;
  logic [N_W2-1:0]     we_w2_r;
  logic [LADDR_W-1:0]  wr_addr_ifm_r, wr_addr_w1_r, wr_addr_w2_r;

  logic [ADDR_W-1:0]   sz_ifm_s, sz_w1_s, sz_w2_s;
  logic [ADDR_W-1:0]   bs_ifm_s, bs_w1_s, bs_w2_s;
  logic [ADDR_W-1:0]   nxt_base_s, cur_size_s;
  state_t              nxt_rd_s;
  phase_t              nxt_tag_s;
  logic                last_issue_s, wr_active_s;

  logic [0:0]          dec_we_ifm_s;
  logic [N_W1-1:0]     dec_we_w1_s;
  logic [N_W2-1:0]     dec_we_w2_s;
  logic [LADDR_W-1:0]  dec_addr_ifm_s, dec_addr_w1_s, dec_addr_w2_s;

  // In IDLE the phase choice comes straight from the inputs being latched on start.
  always_comb begin
    if (state_r == IDLE) begin
      sz_ifm_s = size_IFM;
      sz_w1_s  = size_Weight_layer_1;
      sz_w2_s  = size_Weight_layer_2;
      bs_ifm_s = base_addr_IFM;
      bs_w1_s  = base_addr_Weight_layer_1;
      bs_w2_s  = base_addr_Weight_layer_2;
    end else begin
      sz_ifm_s = size_ifm_r;
      sz_w1_s  = size_w1_r;
      sz_w2_s  = size_w2_r;
      bs_ifm_s = base_ifm_r;
      bs_w1_s  = base_w1_r;
      bs_w2_s  = base_w2_r;
    end
    nxt_rd_s  = next_read_state(state_r, sz_ifm_s != {ADDR_W{1'b0}},
                                sz_w1_s != {ADDR_W{1'b0}}, sz_w2_s != {ADDR_W{1'b0}});
    nxt_tag_s = phase_of(nxt_rd_s);
    case (nxt_rd_s)
      RD_IFM:  nxt_base_s = bs_ifm_s;
      RD_W1:   nxt_base_s = bs_w1_s;
      RD_W2:   nxt_base_s = bs_w2_s;
      default: nxt_base_s = rd_addr_r;
    endcase
    case (state_r)
      RD_IFM:  cur_size_s = size_ifm_r;
      RD_W1:   cur_size_s = size_w1_r;
      RD_W2:   cur_size_s = size_w2_r;
      default: cur_size_s = {ADDR_W{1'b0}};
    endcase
    last_issue_s = (pipe_k_r == cur_size_s - ADDR_W'(1));
    wr_active_s  = we_ifm_r | (|we_w1_r) | (|we_w2_r);
  end

  // Control FSM, issue counter and read-issue pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      base_ifm_r   <= {ADDR_W{1'b0}};
      size_ifm_r   <= {ADDR_W{1'b0}};
      base_w1_r    <= {ADDR_W{1'b0}};
      size_w1_r    <= {ADDR_W{1'b0}};
      base_w2_r    <= {ADDR_W{1'b0}};
      size_w2_r    <= {ADDR_W{1'b0}};
      rd_addr_r    <= {ADDR_W{1'b0}};
      pipe_valid_r <= 1'b0;
      pipe_tag_r   <= PH_IFM;
      pipe_k_r     <= {ADDR_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pipe_valid_r <= 1'b0;
          if (start) begin
            base_ifm_r <= base_addr_IFM;
            size_ifm_r <= size_IFM;
            base_w1_r  <= base_addr_Weight_layer_1;
            size_w1_r  <= size_Weight_layer_1;
            base_w2_r  <= base_addr_Weight_layer_2;
            size_w2_r  <= size_Weight_layer_2;
            busy_r     <= 1'b1;
            state_r    <= nxt_rd_s;
            if (nxt_rd_s != DRAIN) begin
              rd_addr_r    <= nxt_base_s;
              pipe_valid_r <= 1'b1;
              pipe_tag_r   <= nxt_tag_s;
              pipe_k_r     <= {ADDR_W{1'b0}};
            end
          end
        end
        RD_IFM, RD_W1, RD_W2: begin
          if (last_issue_s) begin
            state_r <= nxt_rd_s;
            if (nxt_rd_s != DRAIN) begin
              rd_addr_r    <= nxt_base_s;
              pipe_valid_r <= 1'b1;
              pipe_tag_r   <= nxt_tag_s;
              pipe_k_r     <= {ADDR_W{1'b0}};
            end else begin
              pipe_valid_r <= 1'b0;
            end
          end else begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
            pipe_k_r  <= pipe_k_r + ADDR_W'(1);
          end
        end
        // Hold until the final write has been presented on the write ports.
        DRAIN: begin
          pipe_valid_r <= 1'b0;
          if (!wr_active_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          pipe_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  fused_bank_decode #(.N_BANKS(1), .ADDR_W(ADDR_W), .LADDR_W(LADDR_W), .PHASE(PH_IFM)) u_dec_ifm (
    .valid(pipe_valid_r), .tag(pipe_tag_r), .k(pipe_k_r), .we(dec_we_ifm_s), .addr(dec_addr_ifm_s)
  );

  fused_bank_decode #(.N_BANKS(N_W1), .ADDR_W(ADDR_W), .LADDR_W(LADDR_W), .PHASE(PH_W1)) u_dec_w1 (
    .valid(pipe_valid_r), .tag(pipe_tag_r), .k(pipe_k_r), .we(dec_we_w1_s), .addr(dec_addr_w1_s)
  );

  fused_bank_decode #(.N_BANKS(N_W2), .ADDR_W(ADDR_W), .LADDR_W(LADDR_W), .PHASE(PH_W2)) u_dec_w2 (
    .valid(pipe_valid_r), .tag(pipe_tag_r), .k(pipe_k_r), .we(dec_we_w2_s), .addr(dec_addr_w2_s)
  );

  // Registered write strobes; each class keeps its last address between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_ifm_r      <= 1'b0;
      we_w1_r       <= {N_W1{1'b0}};
      we_w2_r       <= {N_W2{1'b0}};
      wr_addr_ifm_r <= {LADDR_W{1'b0}};
      wr_addr_w1_r  <= {LADDR_W{1'b0}};
      wr_addr_w2_r  <= {LADDR_W{1'b0}};
    end else begin
      we_ifm_r <= dec_we_ifm_s[0];
      we_w1_r  <= dec_we_w1_s;
      we_w2_r  <= dec_we_w2_s;
      if (dec_we_ifm_s[0]) begin
        wr_addr_ifm_r <= dec_addr_ifm_s;
      end
      if (|dec_we_w1_s) begin
        wr_addr_w1_r <= dec_addr_w1_s;
      end
      if (|dec_we_w2_s) begin
        wr_addr_w2_r <= dec_addr_w2_s;
      end
    end
  end

  assign rd_addr_global         = rd_addr_r;
  assign wr_data_fused          = rd_data_global;
  assign we_IFM                 = we_ifm_r;
  assign wr_addr_IFM            = wr_addr_ifm_r;
  assign we_Weight_layer_1      = we_w1_r;
  assign wr_addr_Weight_layer_1 = wr_addr_w1_r;
  assign we_Weight_layer_2      = we_w2_r;
  assign wr_addr_Weight_layer_2 = wr_addr_w2_r;
  assign busy                   = busy_r;
  assign done                   = done_r;

endmodule

// File: tb/tb_fused_load_sequencer.sv
// Scoreboard bench for fused_load_sequencer: a driver queues expected reads,
// writes and done cycles from the transfer rules; a negedge monitor checks them.
module tb_fused_load_sequencer;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [31:0]  base_addr_IFM, size_IFM, base_addr_Weight_layer_1, size_Weight_layer_1;
  logic [31:0]  base_addr_Weight_layer_2, size_Weight_layer_2;
  logic [31:0]  rd_addr_global;
  logic [127:0] rd_data_global, wr_data_fused;
  logic [15:0]  wr_addr_IFM, wr_addr_Weight_layer_1, wr_addr_Weight_layer_2;
  logic         we_IFM;
  logic [15:0]  we_Weight_layer_1;
  logic [3:0]   we_Weight_layer_2;
  logic         busy, done;

  fused_load_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr_IFM(base_addr_IFM), .size_IFM(size_IFM),
    .base_addr_Weight_layer_1(base_addr_Weight_layer_1), .size_Weight_layer_1(size_Weight_layer_1),
    .base_addr_Weight_layer_2(base_addr_Weight_layer_2), .size_Weight_layer_2(size_Weight_layer_2),
    .rd_addr_global(rd_addr_global), .rd_data_global(rd_data_global),
    .wr_data_fused(wr_data_fused),
    .wr_addr_IFM(wr_addr_IFM), .we_IFM(we_IFM),
    .wr_addr_Weight_layer_1(wr_addr_Weight_layer_1), .we_Weight_layer_1(we_Weight_layer_1),
    .wr_addr_Weight_layer_2(wr_addr_Weight_layer_2), .we_Weight_layer_2(we_Weight_layer_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [31:0]  addr;
  } rd_t;

  typedef struct {
    int           cyc;
    int           cls;
    int           bank;
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  rd_t  rd_q[$];
  wr_t  wr_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   busy_lo = 1, busy_hi = 0;
  int   checks = 0, failures = 0;
  logic [31:0] mem_addr_q;

  function automatic logic [127:0] word_of(input logic [31:0] a);
    return {a ^ 32'h5A5A_1234, ~a, a + 32'h0101_0101, {a[15:0], a[31:16]}};
  endfunction

  // Global BRAM: one-cycle registered read.
  always @(posedge clk) mem_addr_q <= rd_addr_global;
  assign rd_data_global = word_of(mem_addr_q);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one start in the current cycle (cycle 0) and queue the expected response.
  task automatic run_op(input logic [31:0] b0, input int s0, input logic [31:0] b1, input int s1,
                        input logic [31:0] b2, input int s2);
    int c0, j, total, dcyc;
    int sz[3];
    logic [31:0] bs[3];
    int nb[3];
    wr_t w;
    rd_t r;
    c0 = cyc;
    sz = '{s0, s1, s2};
    bs = '{b0, b1, b2};
    nb = '{1, 16, 4};
    base_addr_IFM = b0; size_IFM = 32'(s0);
    base_addr_Weight_layer_1 = b1; size_Weight_layer_1 = 32'(s1);
    base_addr_Weight_layer_2 = b2; size_Weight_layer_2 = 32'(s2);
    start = 1'b1;
    j = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < sz[p]; k++) begin
        r.cyc = c0 + 1 + j;
        r.addr = bs[p] + 32'(k);
        rd_q.push_back(r);
        w.cyc = c0 + 2 + j;
        w.cls = p;
        w.bank = k % nb[p];
        w.addr = 16'(k / nb[p]);
        w.data = word_of(bs[p] + 32'(k));
        wr_q.push_back(w);
        j++;
      end
    end
    total = s0 + s1 + s2;
    dcyc = (total == 0) ? c0 + 2 : c0 + total + 3;
    done_q.push_back(dcyc);
    busy_lo = c0 + 1;
    busy_hi = dcyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      chk("op_timeout", 1'b1, 1'b0);
      rd_q.delete(); wr_q.delete(); done_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_addr"}, rd_addr_global, 32'h0);
    chk({tag, "_we"}, {we_IFM, we_Weight_layer_1, we_Weight_layer_2}, 21'h0);
    chk({tag, "_wr_addr"}, {wr_addr_IFM, wr_addr_Weight_layer_1, wr_addr_Weight_layer_2}, 48'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the queues.
  always @(negedge clk) begin : monitor
    rd_t r;
    wr_t w;
    int n, cls, bank;
    logic [15:0] addr;
    if (!reset) begin
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        chk("read_missing", 1'b0, 1'b1);
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        r = rd_q.pop_front();
        chk("rd_addr", rd_addr_global, r.addr);
      end
      n = $countones({we_IFM, we_Weight_layer_1, we_Weight_layer_2});
      if (n != 0) begin
        chk("we_onehot", n, 1);
        bank = 0;
        if (we_IFM) begin
          cls = 0; addr = wr_addr_IFM;
        end else if (|we_Weight_layer_1) begin
          cls = 1; addr = wr_addr_Weight_layer_1;
          for (int i = 0; i < 16; i++) if (we_Weight_layer_1[i]) bank = i;
        end else begin
          cls = 2; addr = wr_addr_Weight_layer_2;
          for (int i = 0; i < 4; i++) if (we_Weight_layer_2[i]) bank = i;
        end
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_class", cls, w.cls);
          chk("wr_bank", bank, w.bank);
          chk("wr_addr", addr, w.addr);
          chk("wr_data", wr_data_fused, w.data);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        chk("write_missing", 1'b0, 1'b1);
        void'(wr_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missing", 1'b0, 1'b1);
        void'(done_q.pop_front());
      end
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int s0, s1, s2;
    logic [31:0] b0;
    reset = 1'b0;
    start = 1'b0;
    base_addr_IFM = 32'h0; size_IFM = 32'h0;
    base_addr_Weight_layer_1 = 32'h0; size_Weight_layer_1 = 32'h0;
    base_addr_Weight_layer_2 = 32'h0; size_Weight_layer_2 = 32'h0;
    #1 reset = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    step();

    run_op(32'h100, 4, 32'h0, 0, 32'h0, 0);
    wait_idle(100);
    step();
    run_op(32'h0, 0, 32'h200, 20, 32'h0, 0);
    wait_idle(100);
    step();
    // 2/3/5 with a second start mid-run that must be ignored.
    run_op(32'h300, 2, 32'h400, 3, 32'h500, 5);
    repeat (3) step();
    size_IFM = 32'd7; size_Weight_layer_1 = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(100);
    step();
    run_op(32'h0, 0, 32'h0, 0, 32'h0, 0);
    wait_idle(100);
    step();
    run_op(32'hFFFF_FFFE, 3, 32'h0, 0, 32'h0, 0);
    wait_idle(100);
    step();

    // Reset in cycle 3 of a 0/20/0 run: everything clears, no done follows.
    run_op(32'h0, 0, 32'h200, 20, 32'h0, 0);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    rd_q.delete(); wr_q.delete(); done_q.delete();
    busy_lo = 1; busy_hi = 0;
    repeat (2) step();
    reset = 1'b0;
    repeat (30) step();
    run_op(32'h0, 0, 32'h200, 20, 32'h0, 0);
    wait_idle(100);

    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(1, 3)) step();
      s0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      s1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      s2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
      b0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      run_op(b0, s0, $urandom, s1, $urandom, s2);
      wait_idle(200);
    end
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
